dpram_bytewr: RTL and testbench

DPRAM_BYTEWR -- requirements
Module: dpram_bytewr

---
 rtl/dpram_pkg.sv | 20 ++
 rtl/dpram_rd_pipe.sv | 62 ++++++
 rtl/dpram_bytewr.sv | 180 ++++++++++++++++++
 tb/tb_dpram_bytewr.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// ----------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the byte-writable dual-port RAM:
//   ctrl_state_t : controller states (INIT clears memory, RUN serves ports)
//   READ_FIRST / WRITE_FIRST : encodings of the same-port read-during-write mode
//   BYTE_W       : width of one byte lane
// ----------------------------------------------------------------------------
package dpram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/dpram_rd_pipe.sv
// ----------------------------------------------------------------------------
// dpram_rd_pipe
// Read-return pipeline for one RAM port. Delays data, valid and the collision
// flag by RD_LAT cycles. Every stage only loads data when its incoming valid
// is set, so the output word holds its last value while valid is low.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes all stages)
//   i_valid    : access accepted this cycle
//   i_data     : word to return for that access
//   i_coll     : access collided with the other port
//   o_data     : registered return word
//   o_valid    : one-cycle pulse qualifying o_data
//   o_coll     : collision flag aligned with o_valid
// ----------------------------------------------------------------------------
module dpram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_coll,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_coll
);

    logic [WIDTH-1:0]  r_data [RD_LAT];
    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_coll;

    // Shift register of RD_LAT stages; collision is only carried alongside a
    // valid access so it can never pulse on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_data[s] <= '0;
            end
            r_valid <= '0;
            r_coll  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_coll[0]  <= i_valid & i_coll;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_coll[s]  <= r_coll[s-1];
                if (r_valid[s-1]) begin
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_data  = r_data[RD_LAT-1];
    assign o_valid = r_valid[RD_LAT-1];
    assign o_coll  = r_coll[RD_LAT-1];

endmodule

// File: rtl/dpram_bytewr.sv
// ----------------------------------------------------------------------------
// dpram_bytewr
// True dual-port RAM with per-byte write enables and a built-in clear. After
// reset the controller walks every address writing zero (INIT), then serves
// both ports (RUN). Every accepted access, read or write, returns a word
// RD_LAT cycles later with an rvalid pulse.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en_x, w_en_x             : access enable, write select (x = a, b)
//   be_x                     : byte-lane write enables
//   addr_x, data_in_x        : word address, write data
//   data_out_x, rvalid_x     : returned word and its qualifying pulse
//   collision                : same-address conflict, aligned with rvalid
//   init_done                : high once the memory clear has finished
// ----------------------------------------------------------------------------
module dpram_bytewr
    import dpram_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 32,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_a,
    input  logic                     w_en_a,
    input  logic [WIDTH/8-1:0]       be_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         data_in_a,
    output logic [WIDTH-1:0]         data_out_a,
    output logic                     rvalid_a,
    input  logic                     en_b,
    input  logic                     w_en_b,
    input  logic [WIDTH/8-1:0]       be_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         data_in_b,
    output logic [WIDTH-1:0]         data_out_b,
    output logic                     rvalid_b,
    output logic                     collision,
    output logic                     init_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LANES  = WIDTH / BYTE_W;

    // Reject configurations the datapath cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dpram_bytewr: DEPTH must be a power of two and >= 2");
    end
    if (WIDTH < BYTE_W || (WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("dpram_bytewr: WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("dpram_bytewr: RD_LAT must be 1 or 2");
    end
    if (RDW_MODE != READ_FIRST && RDW_MODE != WRITE_FIRST) begin : g_bad_rdw
        $error("dpram_bytewr: RDW_MODE must be 0 or 1");
    end

    ctrl_state_t       r_state;
    ctrl_state_t       w_stateNext;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic             w_run;
    logic             w_accA, w_accB;
    logic             w_wrA, w_wrB;
    logic             w_sameAddr;
    logic             w_coll;
    logic [WIDTH-1:0] w_oldA, w_oldB;
    logic [WIDTH-1:0] w_mergeA, w_mergeB;
    logic [WIDTH-1:0] w_retA, w_retB;
    logic             w_collA, w_collB;

    // Controller state register and clear counter. The counter wraps back to
    // zero on the last clear cycle, so it is already clean in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= INIT;
            r_clrCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == INIT) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
        end
    end

    // Leave INIT after the last address has been cleared.
    always_comb begin
        w_stateNext = r_state;
        if (r_state == INIT && r_clrCnt == ADDR_W'(DEPTH - 1)) begin
            w_stateNext = RUN;
        end
    end

    assign w_run      = (r_state == RUN);
    assign w_accA     = w_run & en_a;
    assign w_accB     = w_run & en_b;
    assign w_wrA      = w_accA & w_en_a;
    assign w_wrB      = w_accB & w_en_b;
    assign w_sameAddr = (addr_a == addr_b);
    assign w_coll     = w_accA & w_accB & w_sameAddr & (w_en_a | w_en_b);
    assign w_oldA     = r_mem[addr_a];
    assign w_oldB     = r_mem[addr_b];

    // New word for each port's address. When both ports write the same word,
    // port A owns the lanes it enables and port B fills the rest, so both
    // merges produce the identical word.
    always_comb begin
        w_mergeA = w_oldA;
        w_mergeB = w_oldB;
        for (int l = 0; l < LANES; l++) begin
            if (w_wrA && be_a[l]) begin
                w_mergeA[l*BYTE_W +: BYTE_W] = data_in_a[l*BYTE_W +: BYTE_W];
            end else if (w_wrB && w_sameAddr && be_b[l]) begin
                w_mergeA[l*BYTE_W +: BYTE_W] = data_in_b[l*BYTE_W +: BYTE_W];
            end
            if (w_wrA && w_sameAddr && be_a[l]) begin
                w_mergeB[l*BYTE_W +: BYTE_W] = data_in_a[l*BYTE_W +: BYTE_W];
            end else if (w_wrB && be_b[l]) begin
                w_mergeB[l*BYTE_W +: BYTE_W] = data_in_b[l*BYTE_W +: BYTE_W];
            end
        end
    end

    // Memory array: zero-fill while clearing, port writes while running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == INIT) begin
                r_mem[r_clrCnt] <= '0;
            end else begin
                if (w_wrA) begin
                    r_mem[addr_a] <= w_mergeA;
                end
                if (w_wrB) begin
                    r_mem[addr_b] <= w_mergeB;
                end
            end
        end
    end

    // A reader always sees the pre-write word; a writer sees either the old
    // or the merged word depending on RDW_MODE.
    assign w_retA = (w_wrA && RDW_MODE == WRITE_FIRST) ? w_mergeA : w_oldA;
    assign w_retB = (w_wrB && RDW_MODE == WRITE_FIRST) ? w_mergeB : w_oldB;

    dpram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_pipeA (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accA),
        .i_data  (w_retA),
        .i_coll  (w_coll),
        .o_data  (data_out_a),
        .o_valid (rvalid_a),
        .o_coll  (w_collA)
    );

    dpram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_pipeB (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accB),
        .i_data  (w_retB),
        .i_coll  (w_coll),
        .o_data  (data_out_b),
        .o_valid (rvalid_b),
        .o_coll  (w_collB)
    );

    assign collision = w_collA | w_collB;
    assign init_done = w_run;

endmodule

// File: tb/tb_dpram_bytewr.sv
// ----------------------------------------------------------------------------
// tb_dpram_bytewr
// Bench for dpram_bytewr. The main instance uses default parameters and is
// checked every cycle against a behavioural memory model plus an expected-
// return queue per port. A second instance (RDW_MODE=1, RD_LAT=2) covers the
// write-first, two-cycle-latency configuration.
// ----------------------------------------------------------------------------
module tb_dpram_bytewr;

    localparam int DEPTH = 16;
    localparam int LAT   = 1;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        coll;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enA, wenA, enB, wenB;
    logic [3:0]  beA, beB, addrA, addrB;
    logic [31:0] dinA, dinB;
    logic [31:0] doutA, doutB;
    logic        rvA, rvB, coll, initDone;

    logic        rst2 = 1'b1;
    logic        en2, wen2;
    logic [3:0]  be2, addr2;
    logic [31:0] din2;
    logic [31:0] dout2a, dout2b;
    logic        rv2a, rv2b, coll2, initDone2;

    exp_t        qA[$];
    exp_t        qB[$];
    logic [31:0] mMem [DEPTH];
    logic [31:0] lastA = '0;
    logic [31:0] lastB = '0;
    bit          mRun  = 1'b0;
    int          mCnt  = 0;
    int          cyc   = 0;
    bit          monOn = 1'b0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dpram_bytewr #(.DEPTH(16), .WIDTH(32), .RD_LAT(1), .RDW_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .en_a(enA), .w_en_a(wenA), .be_a(beA), .addr_a(addrA), .data_in_a(dinA),
        .data_out_a(doutA), .rvalid_a(rvA),
        .en_b(enB), .w_en_b(wenB), .be_b(beB), .addr_b(addrB), .data_in_b(dinB),
        .data_out_b(doutB), .rvalid_b(rvB),
        .collision(coll), .init_done(initDone)
    );

    dpram_bytewr #(.DEPTH(16), .WIDTH(32), .RD_LAT(2), .RDW_MODE(1)) dut2 (
        .clk(clk), .rst(rst2),
        .en_a(en2), .w_en_a(wen2), .be_a(be2), .addr_a(addr2), .data_in_a(din2),
        .data_out_a(dout2a), .rvalid_a(rv2a),
        .en_b(1'b0), .w_en_b(1'b0), .be_b(4'h0), .addr_b(4'h0), .data_in_b(32'h0),
        .data_out_b(dout2b), .rvalid_b(rv2b),
        .collision(coll2), .init_done(initDone2)
    );

    // Advance one clock edge and update the model with the inputs that edge
    // sampled. Inputs change only #1 after the edge.
    task automatic cycle();
        logic [31:0] oldA, oldB;
        logic        c;
        @(posedge clk);
        cyc++;
        if (rst) begin
            qA.delete();
            qB.delete();
            mRun  = 1'b0;
            mCnt  = 0;
            lastA = '0;
            lastB = '0;
        end else if (!mRun) begin
            mMem[mCnt] = '0;
            mCnt++;
            if (mCnt == DEPTH) begin
                mRun = 1'b1;
                mCnt = 0;
            end
        end else begin
            oldA = mMem[addrA];
            oldB = mMem[addrB];
            c = enA && enB && (addrA == addrB) && (wenA || wenB);
            if (enA) qA.push_back('{cyc + LAT - 1, oldA, c});
            if (enB) qB.push_back('{cyc + LAT - 1, oldB, c});
            for (int l = 0; l < 4; l++) begin
                if (enB && wenB && beB[l]) mMem[addrB][l*8 +: 8] = dinB[l*8 +: 8];
                if (enA && wenA && beA[l]) mMem[addrA][l*8 +: 8] = dinA[l*8 +: 8];
            end
        end
        #1;
    endtask

    task automatic idle();
        enA = 1'b0; wenA = 1'b0; beA = 4'h0; addrA = 4'h0; dinA = '0;
        enB = 1'b0; wenB = 1'b0; beB = 4'h0; addrB = 4'h0; dinB = '0;
    endtask

    // Scoreboard: pop expected returns when due and check every output.
    always @(negedge clk) begin : monitor
        logic eA, eB, eColl;
        if (monOn) begin
            eA    = (qA.size() > 0) && (qA[0].due == cyc);
            eB    = (qB.size() > 0) && (qB[0].due == cyc);
            eColl = 1'b0;
            total++;
            if (rvA !== eA) begin
                bad++;
                $display("[TB] FAIL rvalid_a cyc=%0d got=%b exp=%b", cyc, rvA, eA);
            end
            if (eA) begin
                lastA = qA[0].data;
                eColl = eColl | qA[0].coll;
                void'(qA.pop_front());
            end
            total++;
            if (doutA !== lastA) begin
                bad++;
                $display("[TB] FAIL data_out_a cyc=%0d got=%h exp=%h", cyc, doutA, lastA);
            end
            total++;
            if (rvB !== eB) begin
                bad++;
                $display("[TB] FAIL rvalid_b cyc=%0d got=%b exp=%b", cyc, rvB, eB);
            end
            if (eB) begin
                lastB = qB[0].data;
                eColl = eColl | qB[0].coll;
                void'(qB.pop_front());
            end
            total++;
            if (doutB !== lastB) begin
                bad++;
                $display("[TB] FAIL data_out_b cyc=%0d got=%h exp=%h", cyc, doutB, lastB);
            end
            total++;
            if (coll !== eColl) begin
                bad++;
                $display("[TB] FAIL collision cyc=%0d got=%b exp=%b", cyc, coll, eColl);
            end
            total++;
            if (initDone !== mRun) begin
                bad++;
                $display("[TB] FAIL init_done cyc=%0d got=%b exp=%b", cyc, initDone, mRun);
            end
        end
    end

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        cycle();
        monOn = 1'b1;
        cycle();
        cycle();
        total++;
        if (initDone !== 1'b0 || doutA !== 32'h0 || rvA !== 1'b0 || coll !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold got init=%b dout=%h rv=%b coll=%b exp 0", initDone, doutA, rvA, coll);
        end
        // Requests during the clear must be ignored.
        rst = 1'b0;
        enA = 1'b1; addrA = 4'd2;
        enB = 1'b1; wenB = 1'b1; beB = 4'hF; dinB = 32'hFFFF_FFFF; addrB = 4'd6;
        n = 0;
        while (!initDone && n < 40) begin
            cycle();
            n++;
        end
        idle();
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL init_latency got=%0d exp=16", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            enA = 1'b1; addrA = 4'(i);
            enB = 1'b1; addrB = 4'(DEPTH - 1 - i);
            cycle();
            total++;
            if (doutA !== 32'h0 || rvA !== 1'b1) begin
                bad++;
                $display("[TB] FAIL clear_read addr=%0d got=%h rv=%b exp=00000000", i, doutA, rvA);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_byte_write();
        enA = 1'b1; wenA = 1'b1; addrA = 4'd3; dinA = 32'hAABB_CCDD; beA = 4'b0101;
        cycle();
        total++;
        if (rvA !== 1'b1 || doutA !== 32'h0) begin
            bad++;
            $display("[TB] FAIL byte_write_return got=%h rv=%b exp=00000000", doutA, rvA);
        end
        wenA = 1'b0;
        cycle();
        total++;
        if (doutA !== 32'h00BB_00DD) begin
            bad++;
            $display("[TB] FAIL byte_write_readback got=%h exp=00bb00dd", doutA);
        end
        // All-zero byte enables leave the word untouched.
        wenA = 1'b1; addrA = 4'd4; dinA = 32'hFFFF_FFFF; beA = 4'b0000;
        cycle();
        wenA = 1'b0;
        cycle();
        total++;
        if (doutA !== 32'h0) begin
            bad++;
            $display("[TB] FAIL be_zero_readback got=%h exp=00000000", doutA);
        end
        idle();
        cycle();
    endtask

    task automatic test_collision();
        enA = 1'b1; wenA = 1'b1; addrA = 4'd5; dinA = 32'h1111_1111; beA = 4'b0011;
        enB = 1'b1; wenB = 1'b1; addrB = 4'd5; dinB = 32'h2222_2222; beB = 4'b1111;
        cycle();
        total++;
        if (coll !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ww_collision got=%b exp=1", coll);
        end
        idle();
        enA = 1'b1; addrA = 4'd5;
        cycle();
        total++;
        if (doutA !== 32'h2222_1111 || coll !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ww_readback got=%h coll=%b exp=22221111 coll=0", doutA, coll);
        end
        idle();
        enA = 1'b1; wenA = 1'b1; addrA = 4'd7; dinA = 32'hDEAD_BEEF; beA = 4'hF;
        enB = 1'b1; addrB = 4'd7;
        cycle();
        total++;
        if (doutB !== 32'h0 || coll !== 1'b1 || rvB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rw_old_word got=%h coll=%b rv=%b exp=00000000 coll=1", doutB, coll, rvB);
        end
        idle();
        enB = 1'b1; addrB = 4'd7;
        cycle();
        total++;
        if (doutB !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL rw_readback got=%h exp=deadbeef", doutB);
        end
        idle();
        cycle();
    endtask

    task automatic test_diff_addr();
        enA = 1'b1; wenA = 1'b1; addrA = 4'd10; dinA = 32'h0A0A_0A0A; beA = 4'hF;
        enB = 1'b1; wenB = 1'b1; addrB = 4'd11; dinB = 32'h0B0B_0B0B; beB = 4'hF;
        cycle();
        total++;
        if (coll !== 1'b0) begin
            bad++;
            $display("[TB] FAIL diff_addr_collision got=%b exp=0", coll);
        end
        idle();
        enA = 1'b1; addrA = 4'd11;
        enB = 1'b1; addrB = 4'd10;
        cycle();
        total++;
        if (doutA !== 32'h0B0B_0B0B || doutB !== 32'h0A0A_0A0A) begin
            bad++;
            $display("[TB] FAIL diff_addr_readback got a=%h b=%h exp a=0b0b0b0b b=0a0a0a0a", doutA, doutB);
        end
        idle();
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            enA   = ($urandom_range(0, 7) != 0);
            wenA  = 1'($urandom_range(0, 1));
            beA   = 4'($urandom_range(0, 15));
            addrA = 4'($urandom_range(0, 3));
            dinA  = $urandom;
            enB   = ($urandom_range(0, 7) != 0);
            wenB  = 1'($urandom_range(0, 1));
            beB   = 4'($urandom_range(0, 15));
            addrB = 4'($urandom_range(0, 3));
            dinB  = $urandom;
            cycle();
        end
        idle();
        cycle();
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        // Reset at clear count 8, with a request presented on the same edge.
        rst = 1'b1;
        enA = 1'b1; addrA = 4'd3;
        cycle();
        total++;
        if (rvA !== 1'b0 || initDone !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_clear_reset got rv=%b init=%b exp 0 0", rvA, initDone);
        end
        idle();
        rst = 1'b0;
        n = 0;
        while (!initDone && n < 40) begin
            cycle();
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL restart_latency got=%0d exp=16", n);
        end
        // A request on the reset edge in RUN is dropped and the clear restarts.
        enA = 1'b1; addrA = 4'd7;
        rst = 1'b1;
        cycle();
        idle();
        rst = 1'b0;
        n = 0;
        while (!initDone && n < 40) begin
            cycle();
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL run_reset_latency got=%0d exp=16", n);
        end
        enA = 1'b1; addrA = 4'd7;
        cycle();
        total++;
        if (doutA !== 32'h0) begin
            bad++;
            $display("[TB] FAIL cleared_after_reset got=%h exp=00000000", doutA);
        end
        idle();
        cycle();
    endtask

    task automatic test_rdw_lat2();
        int n;
        en2 = 1'b0; wen2 = 1'b0; be2 = 4'h0; addr2 = 4'h0; din2 = '0;
        rst2 = 1'b1;
        cycle();
        rst2 = 1'b0;
        n = 0;
        while (!initDone2 && n < 40) begin
            cycle();
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL lat2_init_latency got=%0d exp=16", n);
        end
        en2 = 1'b1; wen2 = 1'b1; be2 = 4'hF; addr2 = 4'd9; din2 = 32'h1234_5678;
        cycle();
        en2 = 1'b0;
        total++;
        if (rv2a !== 1'b0 || dout2a !== 32'h0) begin
            bad++;
            $display("[TB] FAIL lat2_early got rv=%b data=%h exp rv=0 data=00000000", rv2a, dout2a);
        end
        cycle();
        total++;
        if (rv2a !== 1'b1 || dout2a !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL lat2_write_first got rv=%b data=%h exp rv=1 data=12345678", rv2a, dout2a);
        end
        cycle();
        total++;
        if (rv2a !== 1'b0 || dout2a !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL lat2_hold got rv=%b data=%h exp rv=0 data=12345678", rv2a, dout2a);
        end
        en2 = 1'b1; wen2 = 1'b1; be2 = 4'b0001; din2 = 32'hAAAA_AAAA;
        cycle();
        en2 = 1'b0;
        cycle();
        total++;
        if (rv2a !== 1'b1 || dout2a !== 32'h1234_56AA) begin
            bad++;
            $display("[TB] FAIL lat2_merged got rv=%b data=%h exp rv=1 data=123456aa", rv2a, dout2a);
        end
        // Read in flight when reset arrives is discarded.
        en2 = 1'b1; wen2 = 1'b0;
        cycle();
        en2 = 1'b0;
        rst2 = 1'b1;
        cycle();
        rst2 = 1'b0;
        total++;
        if (rv2a !== 1'b0 || dout2a !== 32'h0) begin
            bad++;
            $display("[TB] FAIL lat2_flush got rv=%b data=%h exp rv=0 data=00000000", rv2a, dout2a);
        end
        cycle();
        total++;
        if (rv2a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lat2_flush_late got rv=%b exp=0", rv2a);
        end
    endtask

    initial begin
        idle();
        en2 = 1'b0; wen2 = 1'b0; be2 = 4'h0; addr2 = 4'h0; din2 = '0;
        test_reset();
        test_byte_write();
        test_collision();
        test_diff_addr();
        test_back_to_back();
        test_reset_mid();
        test_rdw_lat2();
        cycle();
        cycle();
        total++;
        if (qA.size() !== 0 || qB.size() !== 0) begin
            bad++;
            $display("[TB] FAIL pending_returns got a=%0d b=%0d exp 0 0", qA.size(), qB.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
